// File: rtl/fir_filter_core.sv
// fir_filter_core: fixed-coefficient 8-tap direct-form FIR filter.
// Signed 16-bit samples in, full-precision signed 32-bit registered result out.
// One sample is consumed on every clock. The accumulator wraps modulo 2^32.
module fir_filter_core #(
  parameter logic signed [15:0] H0 = 16'sd1,
  parameter logic signed [15:0] H1 = 16'sd2,
  parameter logic signed [15:0] H2 = 16'sd3,
  parameter logic signed [15:0] H3 = 16'sd4,
  parameter logic signed [15:0] H4 = 16'sd4,
  parameter logic signed [15:0] H5 = 16'sd3,
  parameter logic signed [15:0] H6 = 16'sd2,
  parameter logic signed [15:0] H7 = 16'sd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] x_in,
  output logic signed [31:0] y_out
);

  localparam int unsigned TAPS = 8;
  localparam logic signed [15:0] COEF [TAPS] = '{H0, H1, H2, H3, H4, H5, H6, H7};

  logic signed [15:0] d [TAPS];
  logic signed [31:0] acc;

  // Sum of products over the current (pre-edge) delay line; operands are
  // sign-extended to 32 bits so each product is exact and the sum wraps.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      acc = acc + (32'(COEF[i[2:0]]) * 32'(d[i[2:0]]));
    end
  end

  // Shift the delay line and register the result; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        d[i[2:0]] <= '0;
      end
      y_out <= '0;
    end else begin
      d[0] <= x_in;
      for (int unsigned i = 1; i < TAPS; i++) begin
        d[i[2:0]] <= d[i[2:0] - 3'd1];
      end
      y_out <= acc;
    end
  end

endmodule

// File: tb/tb_fir_filter_core.sv
// Testbench for fir_filter_core: a history-queue model is checked after every
// edge, and directed vectors carry hand-computed literal expectations.
module tb_fir_filter_core;

  logic               clk;
  logic               reset;
  logic signed [15:0] x_in;
  logic signed [31:0] y_out;

  int checks = 0;
  int errors = 0;

  fir_filter_core dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: every sample taken since the last reset, oldest first.
  int coef [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  int hist [$];
  int model_y;

  always @(posedge reset) hist.delete();

  // Model update and per-edge comparison.
  always @(posedge clk) begin
    int e;
    e = 0;
    if (reset) begin
      hist.delete();
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (k < hist.size()) e += coef[k] * hist[hist.size() - 1 - k];
      end
      hist.push_back(int'(x_in));
    end
    model_y = e;
    #1;
    checks++;
    if (y_out !== 32'(e)) begin
      errors++;
      $display("FAIL model t=%0t y_out=%0d expected=%0d", $time, y_out, e);
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int x);
    @(negedge clk);
    x_in = 16'(x);
    @(posedge clk);
    #2;
  endtask

  int imp_exp   [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
  int burst_in  [16] = '{100, 200, 300, 400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int burst_exp [16] = '{0, 100, 400, 1000, 2000, 2900, 3500, 3600, 3000, 2000,
                         1100, 400, 0, 0, 0, 0};
  int ramp_exp  [9]  = '{0, 500, 1500, 3000, 5000, 7000, 8500, 9500, 10000};

  initial begin
    int sum;
    reset = 1'b1;
    x_in  = 16'sd1234;

    // Reset held with a nonzero input.
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("reset_hold", y_out, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("release_first_edge", y_out, 0);
    step(0);
    chk("release_second_edge", y_out, 1234);
    repeat (7) step(0);
    step(0);
    chk("release_flushed", y_out, 0);

    // Impulse.
    step(1);
    chk("impulse_edge0", y_out, 0);
    for (int j = 0; j < 10; j++) begin
      step(0);
      chk("impulse", y_out, imp_exp[j]);
    end

    // Burst.
    sum = 0;
    for (int j = 0; j < 16; j++) begin
      step(burst_in[j]);
      chk("burst", y_out, burst_exp[j]);
      sum += int'(y_out);
    end
    chk("burst_sum", 32'(sum), 20000);

    // Signed extremes.
    repeat (10) step(-32768);
    chk("min_settle", y_out, -655360);
    repeat (10) step(32767);
    chk("max_settle", y_out, 655340);

    // Mid-stream asynchronous reset.
    repeat (10) step(500);
    chk("steady_500", y_out, 10000);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("async_clear", y_out, 0);
    #1 reset = 1'b0;
    chk("async_clear_after_release", y_out, 0);
    @(posedge clk);
    #2;
    chk("ramp", y_out, ramp_exp[0]);
    for (int j = 1; j < 9; j++) begin
      step(500);
      chk("ramp", y_out, ramp_exp[j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_core.md
# fir_filter_core

Fixed-coefficient, 8-tap direct-form FIR filter for signed 16-bit samples, with a full-precision signed 32-bit registered output. It accepts one sample per clock, with no handshake. It sits in the sample datapath between the upstream sample source and downstream processing. The module is named `fir_filter_core`; it implements the `fir_filter` function.

## Interface
Parameters:
- `H0`..`H7`, defaults 1, 2, 3, 4, 4, 3, 2, 1: signed 16-bit tap coefficients. `H0` applies to the newest sample. The default set is a symmetric low-pass with DC gain 20.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `x_in`  input  16  signed two's-complement sample, sampled every rising edge.
- `y_out`  output  32  signed two's-complement filtered result, registered.

## Operation
- Delay line `d[0..7]`, each signed 16 bits.
- On each rising edge, with `reset` low:
  - `d[0]` <= `x_in`.
  - `d[i]` <= `d[i-1]` for i = 1..7.
  - `y_out` <= `H0*d[0] + H1*d[1] + … + H7*d[7]`, using the pre-edge delay-line values.
- Arithmetic rules:
  - Each product is signed 16×16 -> 32 bits.
  - Accumulation is signed, 32 bits.
  - No rounding, truncation or saturation.
  - If a non-default coefficient set overflows, the sum wraps modulo 2^32.
  - With the default coefficients, overflow cannot occur: |y_out| ≤ 20·32768 = 655360.
- A new sample is consumed every cycle. There is no valid or enable qualifier.
- Asserting `reset`, at any time including mid-stream, immediately forces every `d[i]` and `y_out` to 0, independent of `clk`.
- After `reset` deasserts, filtering restarts from all-zero history.

## Timing
- Reset value: `y_out` = 0 and all taps = 0.
- Latency:
  - A sample sampled at edge n contributes `H0·x` to `y_out` after edge n+1.
  - It contributes `Hk·x` after edge n+1+k.
  - It has fully left the filter after edge n+8; from edge n+9 onward it no longer affects `y_out`.
- Throughput: 1 sample per clock.
- The first sample taken after reset release is the value of `x_in` at the first rising edge with `reset` low. `y_out` stays 0 through that edge.
- `reset` asserted during a rising edge wins: no shift occurs and outputs read 0.
- `x_in` must be stable around the rising edge. Benches drive it on the falling edge.

## Test plan
- **Reset:** assert `reset` with `x_in` = 1234 for 3 cycles -> `y_out` = 0 throughout. Deassert -> `y_out` = 0 until one edge after the first sampled sample.
- **Impulse:** `x_in` = 1 for one cycle, then 0 -> `y_out` on successive edges reads 1, 2, 3, 4, 4, 3, 2, 1, then 0 forever.
- **Burst:** `x_in` = 100, 200, 300, 400, then 0 -> `y_out` reads 100, 400, 1000, 2000, 2900, 3500, 3600, 3000, 2000, 1100, 400, then 0. The outputs sum to 20000.
- **Signed extremes:**
  - `x_in` held at -32768 -> `y_out` settles to -655360 after 8 edges.
  - `x_in` held at 32767 -> `y_out` settles to 655340.
  - No wrap in either case.
- **Mid-stream reset:** during a constant `x_in` = 500 (steady `y_out` = 10000), pulse `reset` between edges -> `y_out` drops to 0 asynchronously. After release it ramps 500, 1500, 3000, 5000, 7000, 8500, 9500, 10000.
